// File: rtl/seg_scan_mux_if.sv
// Display-side bundle of seg_scan_mux: glyph/enable/load inputs from the
// occupancy logic and the scanned select/segment outputs toward the pins.
interface seg_scan_mux_if #(
   parameter int unsigned NUM_DIGITS = 5
);
   localparam int unsigned CODE_W = 5 * NUM_DIGITS;

   logic [CODE_W-1:0]     digit_code;
   logic [NUM_DIGITS-1:0] digit_dp;
   logic [NUM_DIGITS-1:0] digit_en;
   logic                  load;
   logic                  blink;
   logic [NUM_DIGITS-1:0] seg_sel;
   logic [7:0]            seg_data;
   logic                  frame_start;

   modport master (
      output digit_code, digit_dp, digit_en, load, blink,
      input  seg_sel, seg_data, frame_start
   );

   modport slave (
      input  digit_code, digit_dp, digit_en, load, blink,
      output seg_sel, seg_data, frame_start
   );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment scanner with a tear-free shadow buffer and per-slot dead time.
// Optional blink gating is compiled in when SEG_BLINK_EN is defined.
module seg_scan_mux #(
   parameter int unsigned NUM_DIGITS     = 5,
   parameter int unsigned SCAN_DIV       = 50000,
   parameter int unsigned BLANK_CYCLES   = 2,
   parameter int unsigned SEL_ACTIVE_LOW = 0,
   parameter int unsigned SEG_ACTIVE_LOW = 0,
   parameter int unsigned BLINK_FRAMES   = 64
) (
   input logic           clk,
   input logic           rst_n,
   seg_scan_mux_if.slave bus
);
   localparam int unsigned CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
   localparam int unsigned CODE_W = 5 * NUM_DIGITS;
   localparam logic [CODE_W-1:0]     CODE_RST = {NUM_DIGITS{5'd31}};
   localparam logic [NUM_DIGITS-1:0] SEL_IDLE = (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;
   localparam logic [7:0]            SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

   function automatic logic [6:0] decode(input logic [4:0] code);
      logic [6:0] seg;
      case (code)
         5'd0:  seg = 7'h3F;
         5'd1:  seg = 7'h06;
         5'd2:  seg = 7'h5B;
         5'd3:  seg = 7'h4F;
         5'd4:  seg = 7'h66;
         5'd5:  seg = 7'h6D;
         5'd6:  seg = 7'h7D;
         5'd7:  seg = 7'h07;
         5'd8:  seg = 7'h7F;
         5'd9:  seg = 7'h6F;
         5'd10: seg = 7'h77;
         5'd11: seg = 7'h7C;
         5'd12: seg = 7'h39;
         5'd13: seg = 7'h5E;
         5'd14: seg = 7'h79;
         5'd15: seg = 7'h71;
         5'd16: seg = 7'h40;
         5'd17: seg = 7'h73;
         5'd18: seg = 7'h38;
         default: seg = 7'h00;
      endcase
      return seg;
   endfunction

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [CODE_W-1:0]     pend_code_q, pend_code_d, act_code_q, act_code_d;
   logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
   logic                  pend_v_q, pend_v_d;
   logic [NUM_DIGITS-1:0] seg_sel_q, seg_sel_d;
   logic [7:0]            seg_data_q, seg_data_d;
   logic                  frame_start_q, frame_start_d;
   logic                  wrap_slot_c, wrap_frame_c, blank_c, sel_on_c, slot_en_c, slot_dp_c;
   logic [4:0]            slot_code_c;

`ifdef SEG_BLINK_EN
   localparam int unsigned BF_W = $clog2(BLINK_FRAMES + 1);
   logic [BF_W-1:0] blink_cnt_q, blink_cnt_d;
   logic            phase_q, phase_d, blank_q, blank_d;

   // Frame counter toggles the phase; the blank decision is latched per slot so blink=0 restores at a slot edge.
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      blank_d     = blank_q;
      if (wrap_frame_c) begin
         if (blink_cnt_q == BF_W'(BLINK_FRAMES - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BF_W'(1);
         end
      end
      if (wrap_slot_c) blank_d = bus.blink && phase_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         blank_q     <= 1'b0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         blank_q     <= blank_d;
      end
   end

   assign blank_c = blank_q;
`else
   logic unused_blink;
   assign unused_blink = bus.blink;
   assign blank_c      = 1'b0;
`endif

   // Scan position, shadow-buffer commit and registered slot outputs.
   always_comb begin
      wrap_slot_c  = (cnt_q == CNT_W'(SCAN_DIV - 1));
      wrap_frame_c = wrap_slot_c && (idx_q == IDX_W'(NUM_DIGITS - 1));
      cnt_d        = wrap_slot_c ? '0 : cnt_q + CNT_W'(1);
      idx_d        = idx_q;
      if (wrap_slot_c) idx_d = wrap_frame_c ? '0 : idx_q + IDX_W'(1);

      pend_code_d = pend_code_q;
      pend_dp_d   = pend_dp_q;
      pend_v_d    = pend_v_q;
      act_code_d  = act_code_q;
      act_dp_d    = act_dp_q;
      if (bus.load) begin
         pend_code_d = bus.digit_code;
         pend_dp_d   = bus.digit_dp;
         pend_v_d    = 1'b1;
      end
      // A load on the boundary cycle bypasses pending and lands in this frame.
      if (wrap_frame_c) begin
         if (bus.load) begin
            act_code_d = bus.digit_code;
            act_dp_d   = bus.digit_dp;
         end else if (pend_v_q) begin
            act_code_d = pend_code_q;
            act_dp_d   = pend_dp_q;
         end
         pend_v_d = 1'b0;
      end

      slot_code_c = 5'd31;
      slot_dp_c   = 1'b0;
      slot_en_c   = 1'b0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (idx_q == IDX_W'(i)) begin
            slot_code_c = act_code_q[5*i +: 5];
            slot_dp_c   = act_dp_q[i];
            slot_en_c   = bus.digit_en[i];
         end
      end
      sel_on_c      = slot_en_c && (cnt_q >= CNT_W'(BLANK_CYCLES)) && !blank_c;
      seg_sel_d     = (sel_on_c ? (NUM_DIGITS'(1) << idx_q) : '0) ^ SEL_IDLE;
      seg_data_d    = (sel_on_c ? {slot_dp_c, decode(slot_code_c)} : 8'h00) ^ SEG_IDLE;
      frame_start_d = (idx_q == '0) && (cnt_q == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         pend_code_q   <= CODE_RST;
         pend_dp_q     <= '0;
         pend_v_q      <= 1'b0;
         act_code_q    <= CODE_RST;
         act_dp_q      <= '0;
         seg_sel_q     <= SEL_IDLE;
         seg_data_q    <= SEG_IDLE;
         frame_start_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         pend_code_q   <= pend_code_d;
         pend_dp_q     <= pend_dp_d;
         pend_v_q      <= pend_v_d;
         act_code_q    <= act_code_d;
         act_dp_q      <= act_dp_d;
         seg_sel_q     <= seg_sel_d;
         seg_data_q    <= seg_data_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign bus.seg_sel     = seg_sel_q;
   assign bus.seg_data    = seg_data_q;
   assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: 4 digits, 8-cycle slots, 2 dead cycles, plus an inverted-polarity twin.
// Blink stimulus runs when SEG_BLINK_EN is defined.
module tb_seg_scan_mux;
   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = -1;

   always #5 clk = ~clk;

   seg_scan_mux_if #(.NUM_DIGITS(4)) bus ();
   seg_scan_mux_if #(.NUM_DIGITS(4)) bus2 ();

   assign bus2.digit_code = bus.digit_code;
   assign bus2.digit_dp   = bus.digit_dp;
   assign bus2.digit_en   = bus.digit_en;
   assign bus2.load       = bus.load;
   assign bus2.blink      = bus.blink;

   seg_scan_mux #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2), .SEL_ACTIVE_LOW(0),
                  .SEG_ACTIVE_LOW(0), .BLINK_FRAMES(2))
      u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   seg_scan_mux #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2), .SEL_ACTIVE_LOW(1),
                  .SEG_ACTIVE_LOW(1), .BLINK_FRAMES(2))
      u_inv (.clk(clk), .rst_n(rst_n), .bus(bus2));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goto(input int target);
      while (cyc < target) step();
   endtask

   task automatic pulse_load(input logic [19:0] code, input logic [3:0] dp);
      bus.digit_code = code;
      bus.digit_dp   = dp;
      bus.load       = 1'b1;
      step();
      bus.load       = 1'b0;
   endtask

   function automatic logic [19:0] pack(input logic [4:0] c0, input logic [4:0] c1,
                                        input logic [4:0] c2, input logic [4:0] c3);
      return {c3, c2, c1, c0};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc   = -1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n          = 1'b0;
      bus.digit_code = pack(5'd31, 5'd31, 5'd31, 5'd31);
      bus.digit_dp   = 4'b0000;
      bus.digit_en   = 4'b1111;
      bus.load       = 1'b0;
      bus.blink      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sel", 32'(bus.seg_sel), 32'h0);
      chk("rst_data", 32'(bus.seg_data), 32'h00);
      chk("rst_fs", 32'(bus.frame_start), 32'h0);
      chk("rst_inv_sel", 32'(bus2.seg_sel), 32'hF);
      chk("rst_inv_data", 32'(bus2.seg_data), 32'hFF);
      @(negedge clk);
      rst_n = 1'b1;

      // First slot after release: two dead cycles then digit 0 (blank code)
      step();
      chk("c0_fs", 32'(bus.frame_start), 32'h1);
      chk("c0_sel", 32'(bus.seg_sel), 32'h0);
      chk("c0_data", 32'(bus.seg_data), 32'h00);
      step();
      chk("c1_sel", 32'(bus.seg_sel), 32'h0);
      chk("c1_fs", 32'(bus.frame_start), 32'h0);
      step();
      chk("c2_sel", 32'(bus.seg_sel), 32'h1);
      chk("c2_data", 32'(bus.seg_data), 32'h00);
      chk("c2_inv_sel", 32'(bus2.seg_sel), 32'hE);
      chk("c2_inv_data", 32'(bus2.seg_data), 32'hFF);

      // Mid-frame load stays hidden until the next frame
      goto(10);
      pulse_load(pack(5'd3, 5'd16, 5'd17, 5'd18), 4'b0100);
      goto(18);
      chk("old_d2_sel", 32'(bus.seg_sel), 32'h4);
      chk("old_d2_data", 32'(bus.seg_data), 32'h00);
      goto(31);
      chk("c31_fs", 32'(bus.frame_start), 32'h0);
      step();
      chk("c32_fs", 32'(bus.frame_start), 32'h1);
      chk("c32_sel", 32'(bus.seg_sel), 32'h0);
      goto(34);
      chk("new_d0_sel", 32'(bus.seg_sel), 32'h1);
      chk("new_d0_data", 32'(bus.seg_data), 32'h4F);
      chk("new_d0_inv_sel", 32'(bus2.seg_sel), 32'hE);
      chk("new_d0_inv_data", 32'(bus2.seg_data), 32'hB0);
      goto(42);
      chk("new_d1_sel", 32'(bus.seg_sel), 32'h2);
      chk("new_d1_data", 32'(bus.seg_data), 32'h40);
      goto(50);
      chk("new_d2_sel", 32'(bus.seg_sel), 32'h4);
      chk("new_d2_data", 32'(bus.seg_data), 32'hF3);
      goto(58);
      chk("new_d3_sel", 32'(bus.seg_sel), 32'h8);
      chk("new_d3_data", 32'(bus.seg_data), 32'h38);
      goto(64);
      chk("c64_fs", 32'(bus.frame_start), 32'h1);

      // Two loads in one frame: last one wins
      goto(66);
      chk("pre2_d0_data", 32'(bus.seg_data), 32'h4F);
      goto(70);
      pulse_load(pack(5'd5, 5'd16, 5'd17, 5'd18), 4'b0100);
      goto(80);
      pulse_load(pack(5'd9, 5'd16, 5'd17, 5'd18), 4'b0100);
      goto(98);
      chk("last_wins_d0", 32'(bus.seg_data), 32'h6F);
      goto(102);
      chk("last_wins_d0_late", 32'(bus.seg_data), 32'h6F);

      // Load on the boundary cycle appears in the very next slot 0
      goto(126);
      pulse_load(pack(5'd10, 5'd16, 5'd17, 5'd18), 4'b0100);
      step();
      chk("c128_fs", 32'(bus.frame_start), 32'h1);
      goto(130);
      chk("bnd_d0_data", 32'(bus.seg_data), 32'h77);

      // Disabled digit keeps its slot time but stays dark
      goto(140);
      bus.digit_en = 4'b1011;
      goto(146);
      chk("dis_d2_sel", 32'(bus.seg_sel), 32'h0);
      chk("dis_d2_data", 32'(bus.seg_data), 32'h00);
      chk("dis_d2_inv_sel", 32'(bus2.seg_sel), 32'hF);
      goto(151);
      chk("dis_d2_sel_end", 32'(bus.seg_sel), 32'h0);
      goto(154);
      chk("dis_d3_sel", 32'(bus.seg_sel), 32'h8);
      chk("dis_d3_data", 32'(bus.seg_data), 32'h38);
      goto(159);
      chk("c159_fs", 32'(bus.frame_start), 32'h0);
      step();
      chk("c160_fs", 32'(bus.frame_start), 32'h1);
      bus.digit_en = 4'b1111;

      // Reset mid-frame with a pending load
      goto(170);
      pulse_load(pack(5'd7, 5'd16, 5'd17, 5'd18), 4'b0000);
      goto(178);
      chk("pre_rst_sel", 32'(bus.seg_sel), 32'h4);
      chk("pre_rst_data", 32'(bus.seg_data), 32'hF3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_sel", 32'(bus.seg_sel), 32'h0);
      chk("midrst_data", 32'(bus.seg_data), 32'h00);
      chk("midrst_fs", 32'(bus.frame_start), 32'h0);
      chk("midrst_inv_sel", 32'(bus2.seg_sel), 32'hF);
      chk("midrst_inv_data", 32'(bus2.seg_data), 32'hFF);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc   = -1;
      step();
      chk("post_rst_fs", 32'(bus.frame_start), 32'h1);
      goto(2);
      chk("post_rst_d0_sel", 32'(bus.seg_sel), 32'h1);
      chk("post_rst_d0_data", 32'(bus.seg_data), 32'h00);
      goto(34);
      chk("no_stale_d0", 32'(bus.seg_data), 32'h00);
      goto(50);
      chk("no_stale_d2", 32'(bus.seg_data), 32'h00);

`ifdef SEG_BLINK_EN
      // Blink: two frames visible, two blank, repeating
      bus.blink = 1'b1;
      do_reset();
      step();
      goto(5);
      pulse_load(pack(5'd8, 5'd31, 5'd31, 5'd31), 4'b0000);
      goto(34);
      chk("blk_f1_sel", 32'(bus.seg_sel), 32'h1);
      chk("blk_f1_data", 32'(bus.seg_data), 32'h7F);
      goto(66);
      chk("blk_f2_sel", 32'(bus.seg_sel), 32'h0);
      chk("blk_f2_data", 32'(bus.seg_data), 32'h00);
      goto(98);
      chk("blk_f3_sel", 32'(bus.seg_sel), 32'h0);
      goto(130);
      chk("blk_f4_sel", 32'(bus.seg_sel), 32'h1);
      chk("blk_f4_data", 32'(bus.seg_data), 32'h7F);
      goto(162);
      chk("blk_f5_sel", 32'(bus.seg_sel), 32'h1);
      goto(194);
      chk("blk_f6_sel", 32'(bus.seg_sel), 32'h0);
      goto(196);
      bus.blink = 1'b0;
      goto(197);
      chk("blk_off_same_slot", 32'(bus.seg_sel), 32'h0);
      goto(202);
      chk("blk_off_next_slot", 32'(bus.seg_sel), 32'h2);
`else
      // Without the blink feature the request has no effect
      bus.blink = 1'b1;
      goto(66);
      chk("noblk_f2_sel", 32'(bus.seg_sel), 32'h1);
      goto(98);
      chk("noblk_f3_sel", 32'(bus.seg_sel), 32'h1);
      bus.blink = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised time-multiplexed seven-segment driver for the parking-status display. It scans NUM_DIGITS common-select digits at a programmable refresh rate and decodes a per-digit 5-bit glyph code (hex, '-', 'P', 'L', blank) plus decimal point. A shadow buffer keeps every frame tear-free, and a dead-time window at the start of each slot suppresses ghosting. It sits between the occupancy/counter logic and the board's segment pins.

## Interface
- NUM_DIGITS, 5: digits scanned; legal range 2..8.
- SCAN_DIV, 50000: clock cycles per digit slot; must be at least BLANK_CYCLES+2.
- BLANK_CYCLES, 2: cycles at the start of each slot with all selects inactive.
- SEL_ACTIVE_LOW, 0: 1 inverts all seg_sel bits.
- SEG_ACTIVE_LOW, 0: 1 inverts all seg_data bits.
- BLINK_FRAMES, 64: frames per blink half-period; used only when SEG_BLINK_EN is defined.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- digit_code  in  5*NUM_DIGITS  glyph code; digit i is bits [5i+4:5i].
- digit_dp  in  NUM_DIGITS  decimal point per digit.
- digit_en  in  NUM_DIGITS  live digit enable; 0 blanks the digit for its slot.
- load  in  1  one-cycle strobe that captures digit_code/digit_dp into the pending buffer.
- blink  in  1  blink request; ignored without SEG_BLINK_EN.
- seg_sel  out  NUM_DIGITS  one-hot digit select (logical polarity shown before inversion).
- seg_data  out  8  {dp,g,f,e,d,c,b,a}.
- frame_start  out  1  one-cycle pulse at the start of slot 0.

## Operation
- Prescaler cnt runs 0..SCAN_DIV-1, then wraps to 0. On the wrap, idx advances; NUM_DIGITS-1 wraps to 0.
- Decode (gfedcba) for codes 0..15: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71. Code 16 = 40 ('-'), 17 = 73 ('P'), 18 = 38 ('L'), 19..31 = 00 (blank). Bit 7 = dp.
- Slot output:
  - seg_data = decode(active[idx]) | dp<<7.
  - seg_sel = onehot(idx) only when cnt >= BLANK_CYCLES and digit_en[idx]=1; otherwise all inactive.
  - seg_data is forced blank whenever seg_sel is inactive.
- Buffering:
  - load copies inputs into pending and sets pend_v.
  - At a frame boundary (idx wraps to 0) with pend_v=1, active <= pending and pend_v clears.
  - Several loads within one frame: the last one wins.
  - load coinciding with a boundary cycle: the newly presented inputs commit directly to active and pend_v ends at 0.
- Disabled digits keep their slot time, so the frame rate is constant at NUM_DIGITS*SCAN_DIV.
- Reset values:
  - cnt=0, idx=0, pend_v=0, every active/pending code = 31 (blank), dp=0.
  - seg_sel all inactive, seg_data blank (both after polarity inversion), frame_start=0.
  - Reset mid-frame aborts the frame; a pending load is discarded.

## Timing
- All outputs are registered and updated together from the same (idx, cnt) state, one clock after that state. seg_sel and seg_data therefore never skew.
- Slot k occupies SCAN_DIV cycles:
  - BLANK_CYCLES cycles all-inactive.
  - SCAN_DIV-BLANK_CYCLES cycles driving digit k.
- frame_start is high for exactly the first output cycle of slot 0 and coincides with the first cycle in which the newly committed buffer is visible.
- Latency from load to display: commit at the next frame boundary, then visible after BLANK_CYCLES more cycles in slot 0.
- After reset release, slot 0 begins with frame_start on the first output update.

## Configuration
- SEG_BLINK_EN defined:
  - A frame counter (0..BLINK_FRAMES-1) toggles a phase bit on each wrap.
  - While blink=1 and phase=1, all selects are inactive for whole frames.
  - blink going 0 restores the display at the next slot boundary.
  - The counter and phase reset to 0.
- SEG_BLINK_EN undefined: no counter logic; the blink input is unused and the display is never blanked by it.

## Test plan
- NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2; release reset -> seg_sel=0000 and seg_data=00 for 2 cycles, then 0001 with data 00 (blank codes); frame_start every 32 cycles.
- load codes {3,16,17,18} with dp=0100 mid-frame -> old data until the next frame_start; then digit0=4F, digit1=40, digit2=F3, digit3=38.
- Two loads in one frame (5, then 9 on digit0) -> only 6F ever appears; load on a boundary cycle -> value shown in that frame's slot 0.
- digit_en=1011 -> slot 2 fully blank with select inactive, frame period still 32 cycles; SEL_ACTIVE_LOW=1 -> idle seg_sel=1111.
- Assert rst_n low during slot 2 with pend_v set -> outputs blank immediately; after release the old pending value never appears.
- SEG_BLINK_EN, BLINK_FRAMES=2, blink=1 -> 2 frames visible, 2 frames blank, repeating; blink=0 -> visible from the next slot.
